// File: rtl/fifo_nibble_tx.sv
// Drain stage for the 4-bit nibble FIFO: pops one nibble per frame and sends it serially
// as start, 4 data bits LSB first, parity and stop bit, with the line idling high.
module fifo_nibble_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic       parity_odd,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_rd_data,
  output logic       fifo_rd_en,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frames_sent
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_CAPTURE = 3'd2,
    S_START   = 3'd3,
    S_DATA    = 3'd4,
    S_PARITY  = 3'd5,
    S_STOP    = 3'd6
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(CLKS_PER_BIT - 1);

  function automatic logic nibble_parity(input logic [3:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  state_t     state_r, state_next_s;
  logic [7:0] cnt_r, cnt_next_s;
  logic [1:0] bit_idx_r, bit_idx_next_s;
  logic [3:0] shreg_r, shreg_next_s;
  logic       parity_r, parity_next_s;
  logic       tx_out_r, tx_next_s;
  logic       rd_en_r, rd_en_next_s;
  logic       busy_r, busy_next_s;
  logic       done_r, done_next_s;
  logic [7:0] frames_r;
  logic       bit_end_s;
  logic       go_s;
  logic       last_stop_s;

  assign bit_end_s   = (cnt_r == CNT_LAST);
  assign go_s        = tx_en & ~fifo_empty;
  assign last_stop_s = (state_r == S_STOP) && bit_end_s;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= 8'd0;
      bit_idx_r <= 2'd0;
      shreg_r   <= 4'd0;
      parity_r  <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      bit_idx_r <= bit_idx_next_s;
      shreg_r   <= shreg_next_s;
      parity_r  <= parity_next_s;
    end
  end

  // Next-state decision
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE:    if (go_s) state_next_s = S_POP; else state_next_s = S_IDLE;
      S_POP:     state_next_s = S_CAPTURE;
      S_CAPTURE: state_next_s = S_START;
      S_START:   if (bit_end_s) state_next_s = S_DATA; else state_next_s = S_START;
      S_DATA: begin
        if (bit_end_s && (bit_idx_r == 2'd3)) state_next_s = S_PARITY;
        else                                  state_next_s = S_DATA;
      end
      S_PARITY:  if (bit_end_s) state_next_s = S_STOP; else state_next_s = S_PARITY;
      S_STOP: begin
        if (bit_end_s) begin
          if (go_s) state_next_s = S_POP;
          else      state_next_s = S_IDLE;
        end else begin
          state_next_s = S_STOP;
        end
      end
      default:   state_next_s = S_IDLE;
    endcase
  end

  // Bit timing, bit index and shift register; the counter restarts on every state change
  always_comb begin
    cnt_next_s     = cnt_r;
    bit_idx_next_s = bit_idx_r;
    shreg_next_s   = shreg_r;
    parity_next_s  = parity_r;
    if ((state_next_s != state_r) || bit_end_s) cnt_next_s = 8'd0;
    else                                        cnt_next_s = cnt_r + 8'd1;
    if (state_r != S_DATA)  bit_idx_next_s = 2'd0;
    else if (bit_end_s)     bit_idx_next_s = bit_idx_r + 2'd1;
    else                    bit_idx_next_s = bit_idx_r;
    if (state_r == S_CAPTURE) begin
      shreg_next_s  = fifo_rd_data;
      parity_next_s = nibble_parity(fifo_rd_data, parity_odd);
    end else if ((state_r == S_DATA) && bit_end_s) begin
      shreg_next_s  = {1'b0, shreg_r[3:1]};
      parity_next_s = parity_r;
    end else begin
      shreg_next_s  = shreg_r;
      parity_next_s = parity_r;
    end
  end

  // Output decode from next-state values so the outputs themselves come straight from flops
  always_comb begin
    tx_next_s    = 1'b1;
    rd_en_next_s = (state_next_s == S_POP);
    busy_next_s  = (state_next_s != S_IDLE);
    done_next_s  = (state_next_s == S_STOP) && (cnt_next_s == CNT_LAST);
    case (state_next_s)
      S_START:  tx_next_s = 1'b0;
      S_DATA:   tx_next_s = shreg_next_s[0];
      S_PARITY: tx_next_s = parity_next_s;
      default:  tx_next_s = 1'b1;
    endcase
  end

  // Output registers and completed-frame counter
  always_ff @(posedge clk) begin
    if (rst_n) begin
      tx_out_r <= 1'b1;
      rd_en_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      frames_r <= 8'd0;
    end else begin
      tx_out_r <= tx_next_s;
      rd_en_r  <= rd_en_next_s;
      busy_r   <= busy_next_s;
      done_r   <= done_next_s;
      if (last_stop_s) frames_r <= frames_r + 8'd1;
      else             frames_r <= frames_r;
    end
  end

  assign tx_out      = tx_out_r;
  assign fifo_rd_en  = rd_en_r;
  assign busy        = busy_r;
  assign frame_done  = done_r;
  assign frames_sent = frames_r;

endmodule

// File: tb/tb_fifo_nibble_tx.sv
// Bench for fifo_nibble_tx: one instance at 4 clocks per bit, one at 1 clock per bit,
// each fed by a simple FIFO model; frames are checked cycle by cycle against a reference.
module tb_fifo_nibble_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, parity_odd, tx_en4, tx_en1, sel1;
  logic       fifo_empty4, fifo_empty1;
  logic [3:0] rd_data4, rd_data1;
  logic       rd_en4, rd_en1, tx4, tx1, busy4, busy1, done4, done1;
  logic [7:0] frames4, frames1;

  logic [3:0] mem4 [0:1023];
  logic [3:0] mem1 [0:1023];
  int push4 = 0, pop4 = 0, push1 = 0, pop1 = 0, under4 = 0, under1 = 0;
  int total = 0, bad = 0;

  fifo_nibble_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en4), .parity_odd(parity_odd),
    .fifo_empty(fifo_empty4), .fifo_rd_data(rd_data4), .fifo_rd_en(rd_en4),
    .tx_out(tx4), .busy(busy4), .frame_done(done4), .frames_sent(frames4));

  fifo_nibble_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_en(tx_en1), .parity_odd(parity_odd),
    .fifo_empty(fifo_empty1), .fifo_rd_data(rd_data1), .fifo_rd_en(rd_en1),
    .tx_out(tx1), .busy(busy1), .frame_done(done1), .frames_sent(frames1));

  assign fifo_empty4 = (push4 == pop4);
  assign fifo_empty1 = (push1 == pop1);

  always @(posedge clk) begin
    if (rd_en4) begin
      if (push4 != pop4) begin
        rd_data4 <= mem4[pop4[9:0]];
        pop4     <= pop4 + 1;
      end else begin
        under4 <= under4 + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (rd_en1) begin
      if (push1 != pop1) begin
        rd_data1 <= mem1[pop1[9:0]];
        pop1     <= pop1 + 1;
      end else begin
        under1 <= under1 + 1;
      end
    end
  end

  wire       m_tx     = sel1 ? tx1     : tx4;
  wire       m_busy   = sel1 ? busy1   : busy4;
  wire       m_rd_en  = sel1 ? rd_en1  : rd_en4;
  wire       m_done   = sel1 ? done1   : done4;
  wire [7:0] m_frames = sel1 ? frames1 : frames4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Line image of a frame, index 0 = start bit ... index 6 = stop bit
  function automatic logic [6:0] frame_model(input logic [3:0] d, input logic odd);
    int ones;
    logic par;
    ones = 0;
    for (int i = 0; i < 4; i++) ones += int'(d[i]);
    par = ((ones + int'(odd)) % 2) == 1;
    return {1'b1, par, d, 1'b0};
  endfunction

  task automatic push(input logic which, input logic [3:0] d);
    if (which) begin
      mem1[push1[9:0]] = d;
      push1++;
    end else begin
      mem4[push4[9:0]] = d;
      push4++;
    end
  endtask

  task automatic wait_start(output int lat, output int rds);
    lat = 0;
    rds = 0;
    while (m_tx !== 1'b0 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (m_rd_en === 1'b1) rds++;
    end
  endtask

  // Starts at the first start-bit cycle and ends on the cycle after the last stop cycle
  task automatic frame_bits(input logic [6:0] exp, input int cpb, input string nm, input int drop_at);
    int errs, dn, rds;
    errs = 0; dn = 0; rds = 0;
    for (int i = 0; i < 7 * cpb; i++) begin
      if (i == drop_at) begin
        tx_en4 = 1'b0;
        tx_en1 = 1'b0;
      end
      if (m_tx !== exp[i / cpb]) errs++;
      if (m_busy !== 1'b1) errs++;
      if (m_rd_en === 1'b1) rds++;
      if (m_done === 1'b1) begin
        dn++;
        if (i != 7 * cpb - 1) errs++;
      end
      @(negedge clk);
    end
    chk({nm, " bits"}, errs, 0);
    chk({nm, " done"}, dn, 1);
    chk({nm, " rd_en in frame"}, rds, 0);
  endtask

  task automatic single(input logic which, input logic [3:0] d, input logic odd,
                        input logic [6:0] exp, input int cpb, input string nm);
    int lat, rds;
    logic [7:0] f0;
    sel1 = which;
    #1;
    f0 = m_frames;
    parity_odd = odd;
    push(which, d);
    if (which) tx_en1 = 1'b1; else tx_en4 = 1'b1;
    wait_start(lat, rds);
    chk({nm, " latency"}, lat, 3);
    chk({nm, " pops"}, rds, 1);
    frame_bits(exp, cpb, nm, 0);
    chk({nm, " busy after"}, m_busy, 0);
    chk({nm, " frames"}, m_frames, 8'(f0 + 8'd1));
  endtask

  typedef struct {
    logic [3:0] d;
    logic       odd;
    logic [6:0] exp;
  } vec_t;
  vec_t tv [6];

  initial begin
    int lat, rds, cnt, dn;
    logic [3:0] rd;
    logic       ro;
    tv[0] = '{4'hA, 1'b0, 7'b1010100};
    tv[1] = '{4'hB, 1'b1, 7'b1010110};
    tv[2] = '{4'hC, 1'b0, 7'b1011000};
    tv[3] = '{4'h0, 1'b1, 7'b1100000};
    tv[4] = '{4'hF, 1'b0, 7'b1011110};
    tv[5] = '{4'h7, 1'b0, 7'b1101110};

    rst_n = 1'b1; parity_odd = 1'b0; tx_en4 = 1'b0; tx_en1 = 1'b0; sel1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst tx4", tx4, 1); chk("rst tx1", tx1, 1);
    chk("rst busy4", busy4, 0); chk("rst rd_en4", rd_en4, 0);
    chk("rst done4", done4, 0); chk("rst frames4", frames4, 0);
    chk("rst frames1", frames1, 0);
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) single(1'b0, tv[i].d, tv[i].odd, tv[i].exp, 4, $sformatf("vec%0d", i));

    // back-to-back 0xA then 0xC
    sel1 = 1'b0; parity_odd = 1'b0;
    push(1'b0, 4'hA); push(1'b0, 4'hC);
    tx_en4 = 1'b1;
    wait_start(lat, rds);
    chk("b2b latency", lat, 3);
    frame_bits(7'b1010100, 4, "b2b A", -1);
    chk("b2b pop2", rd_en4, 1); chk("b2b gap1 tx", tx4, 1); chk("b2b gap busy", busy4, 1);
    tx_en4 = 1'b0;
    @(negedge clk);
    chk("b2b gap2 tx", tx4, 1); chk("b2b gap2 rd_en", rd_en4, 0);
    @(negedge clk);
    chk("b2b C start", tx4, 0);
    frame_bits(7'b1011000, 4, "b2b C", -1);
    chk("b2b busy after", busy4, 0);
    chk("b2b frames", frames4, 8);

    // empty FIFO: nothing happens
    tx_en4 = 1'b1; cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (busy4 !== 1'b0 || rd_en4 !== 1'b0) cnt++;
    end
    chk("empty idle", cnt, 0);
    tx_en4 = 1'b0;

    // tx_en dropped during DATA
    push(1'b0, 4'h5); push(1'b0, 4'h6);
    tx_en4 = 1'b1;
    wait_start(lat, rds);
    frame_bits(frame_model(4'h5, 1'b0), 4, "drop", 8);
    cnt = 0;
    repeat (20) begin
      if (busy4 !== 1'b0 || rd_en4 !== 1'b0) cnt++;
      @(negedge clk);
    end
    chk("drop idle", cnt, 0);
    chk("drop fifo left", push4 - pop4, 1);
    tx_en4 = 1'b1;
    wait_start(lat, rds);
    chk("drain latency", lat, 3);
    frame_bits(frame_model(4'h6, 1'b0), 4, "drain", 0);

    for (int i = 0; i < 16; i++) begin
      rd = 4'($urandom_range(0, 15)); ro = 1'($urandom_range(0, 1));
      single(1'b0, rd, ro, frame_model(rd, ro), 4, $sformatf("rand%0d", i));
    end

    single(1'b1, 4'hA, 1'b0, 7'b1010100, 1, "cpb1 A");
    for (int i = 0; i < 8; i++) begin
      rd = 4'($urandom_range(0, 15)); ro = 1'($urandom_range(0, 1));
      single(1'b1, rd, ro, frame_model(rd, ro), 1, $sformatf("cpb1 rand%0d", i));
    end

    // reset mid-frame
    sel1 = 1'b0; parity_odd = 1'b0;
    push(1'b0, 4'h9); push(1'b1, 4'h9);
    tx_en4 = 1'b1; tx_en1 = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre-reset in frame", busy4, 1);
    tx_en4 = 1'b0; tx_en1 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid rst tx4", tx4, 1); chk("mid rst busy4", busy4, 0);
    chk("mid rst frames4", frames4, 0); chk("mid rst frames1", frames1, 0);
    @(negedge clk);
    rst_n = 1'b0;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (rd_en4 !== 1'b0 || busy4 !== 1'b0 || tx4 !== 1'b1) cnt++;
    end
    chk("post rst quiet", cnt, 0);

    // 256 frames wrap the counter
    sel1 = 1'b1;
    for (int i = 0; i < 256; i++) push(1'b1, 4'($urandom_range(0, 15)));
    tx_en1 = 1'b1; dn = 0; cnt = 0;
    while (cnt < 3000 && !(pop1 == push1 && busy1 === 1'b0 && cnt > 5)) begin
      @(negedge clk);
      cnt++;
      if (done1 === 1'b1) dn++;
    end
    tx_en1 = 1'b0;
    chk("wrap done count", dn, 256);
    chk("wrap frames", frames1, 0);

    chk("underflow4", under4, 0);
    chk("underflow1", under1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
